// File: rtl/trap_csr_unit_if.sv
// ============================================================================
// Module      : trap_csr_unit_if
// Description : Decoder/pipeline-facing bundle of the machine-mode trap and CSR
//               unit: CSR op strobes, trap/MRET strobes, interrupt lines and
//               the redirect/suppress outputs back to the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trap_csr_unit_if #(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 4
);
    // Execute-stage instruction and decoder strobes
    logic                instr_valid;
    logic [XLEN-1:0]     ex_pc;
    logic [11:0]         csr_addr;
    logic [XLEN-1:0]     csr_wdata;
    logic                csr_write;
    logic                csr_set;
    logic                csr_clear;
    logic                illegal_instr;
    logic                mret;
    // Raw asynchronous interrupt lines
    logic [NUM_IRQ-1:0]  irq;
    // Results back to the pipeline
    logic [XLEN-1:0]     csr_rdata;
    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;
    logic                busy;
    logic                ex_suppress;

    // Pipeline / decoder side
    modport master (
        output instr_valid, ex_pc, csr_addr, csr_wdata,
               csr_write, csr_set, csr_clear, illegal_instr, mret, irq,
        input  csr_rdata, redirect_valid, redirect_pc, busy, ex_suppress
    );

    // Trap/CSR unit side
    modport slave (
        input  instr_valid, ex_pc, csr_addr, csr_wdata,
               csr_write, csr_set, csr_clear, illegal_instr, mret, irq,
        output csr_rdata, redirect_valid, redirect_pc, busy, ex_suppress
    );
endinterface

`default_nettype wire

// File: rtl/trap_csr_unit.sv
// ============================================================================
// Module      : trap_csr_unit
// Description : Machine-mode trap and CSR unit. Holds mstatus/mie/mip/mtvec/
//               mscratch/mepc/mcause, synchronises external interrupt lines,
//               accepts illegal-instruction exceptions and level interrupts,
//               and issues a one-cycle PC redirect on trap entry or MRET.
//               Optional feature macro: VECTORED_MTVEC_EN (vectored mtvec
//               mode for interrupts; when undefined mtvec[1:0] reads 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_csr_unit #(
    parameter int              XLEN        = 32,
    parameter int              NUM_IRQ     = 4,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    trap_csr_unit_if.slave     bus
);

    // CSR addresses
    localparam logic [11:0] c_addr_mstatus  = 12'h300;
    localparam logic [11:0] c_addr_mie      = 12'h304;
    localparam logic [11:0] c_addr_mtvec    = 12'h305;
    localparam logic [11:0] c_addr_mscratch = 12'h340;
    localparam logic [11:0] c_addr_mepc     = 12'h341;
    localparam logic [11:0] c_addr_mcause   = 12'h342;
    localparam logic [11:0] c_addr_mip      = 12'h344;

    // Interrupt line i lives at bit/cause 16+i
    localparam int          c_irq_base      = 16;
    localparam logic [XLEN-1:0] c_cause_illegal = XLEN'(2);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_RET  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Architectural state
    logic                r_mstatus_mie;
    logic                r_mstatus_mpie;
    logic [NUM_IRQ-1:0]  r_mie_en;
    logic [XLEN-1:2]     r_mtvec_base;
    logic [XLEN-1:0]     r_mscratch;
    logic [XLEN-1:2]     r_mepc;
    logic [XLEN-1:0]     r_mcause;
    logic [NUM_IRQ-1:0]  r_irq_s1;
    logic [NUM_IRQ-1:0]  r_irq_s2;
`ifdef VECTORED_MTVEC_EN
    localparam logic     c_mtvec_mode_rst = (MTVEC_RESET[1:0] == 2'b01);
    logic                r_mtvec_mode;
`endif

    // Decision wires
    logic                w_run;
    logic [NUM_IRQ-1:0]  w_pending;
    logic                w_exc;
    logic                w_int;
    logic                w_take_trap;
    logic                w_do_mret;
    logic                w_csr_op;
    logic                w_csr_we;
    logic [3:0]          w_irq_idx;
    logic [4:0]          w_irq_code;
    logic [XLEN-1:0]     w_int_cause;
    logic [XLEN-1:0]     w_csr_old;
    logic [XLEN-1:0]     w_csr_new;
    logic [XLEN-1:0]     w_mstatus_val;
    logic [XLEN-1:0]     w_mie_val;
    logic [XLEN-1:0]     w_mip_val;
    logic [XLEN-1:0]     w_mtvec_val;
    logic [XLEN-1:0]     w_trap_target;
    logic                w_redirect_valid;
    logic [XLEN-1:0]     w_redirect_pc;
    logic                w_busy;
    logic                w_unused;

    // The PC low bits are never stored: mepc is always word aligned
    assign w_unused = &{1'b0, bus.ex_pc[1:0]};

    // ------------------------------------------------------------------
    // Trap / MRET / CSR-op qualification (only meaningful in RUN)
    // ------------------------------------------------------------------
    assign w_run       = (r_state == ST_RUN);
    assign w_pending   = r_irq_s2 & r_mie_en;
    assign w_exc       = w_run & bus.instr_valid & bus.illegal_instr;
    assign w_int       = w_run & bus.instr_valid & r_mstatus_mie
                         & (|w_pending) & ~w_exc;
    assign w_take_trap = w_exc | w_int;
    assign w_do_mret   = w_run & bus.instr_valid & bus.mret & ~w_take_trap;
    assign w_csr_op    = bus.csr_write | bus.csr_set | bus.csr_clear;
    assign w_csr_we    = w_run & bus.instr_valid & w_csr_op
                         & ~w_take_trap & ~w_do_mret;

    // Lowest-numbered pending line wins: scan downwards so the last hit sticks
    always_comb begin
        w_irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_irq_idx = 4'(i);
            end
        end
    end

    assign w_irq_code  = 5'(c_irq_base) + {1'b0, w_irq_idx};
    assign w_int_cause = {1'b1, {(XLEN-6){1'b0}}, w_irq_code};

    // ------------------------------------------------------------------
    // CSR read view and read-modify-write value
    // ------------------------------------------------------------------
    // Assemble the read-back images of the sparse CSRs
    always_comb begin
        w_mstatus_val        = '0;
        w_mstatus_val[12:11] = 2'b11;
        w_mstatus_val[7]     = r_mstatus_mpie;
        w_mstatus_val[3]     = r_mstatus_mie;
        w_mie_val            = '0;
        w_mie_val[c_irq_base +: NUM_IRQ] = r_mie_en;
        w_mip_val            = '0;
        w_mip_val[c_irq_base +: NUM_IRQ] = r_irq_s2;
    end

`ifdef VECTORED_MTVEC_EN
    assign w_mtvec_val = {r_mtvec_base, 1'b0, r_mtvec_mode};
`else
    assign w_mtvec_val = {r_mtvec_base, 2'b00};
`endif

    // Old value of the addressed CSR; unimplemented addresses read zero
    always_comb begin
        w_csr_old = '0;
        case (bus.csr_addr)
            c_addr_mstatus:  w_csr_old = w_mstatus_val;
            c_addr_mie:      w_csr_old = w_mie_val;
            c_addr_mtvec:    w_csr_old = w_mtvec_val;
            c_addr_mscratch: w_csr_old = r_mscratch;
            c_addr_mepc:     w_csr_old = {r_mepc, 2'b00};
            c_addr_mcause:   w_csr_old = r_mcause;
            c_addr_mip:      w_csr_old = w_mip_val;
            default:         w_csr_old = '0;
        endcase
    end

    // Write replaces, set ORs in, clear masks out
    always_comb begin
        w_csr_new = w_csr_old;
        if (bus.csr_write) begin
            w_csr_new = bus.csr_wdata;
        end else if (bus.csr_set) begin
            w_csr_new = w_csr_old | bus.csr_wdata;
        end else if (bus.csr_clear) begin
            w_csr_new = w_csr_old & ~bus.csr_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt synchroniser
    // ------------------------------------------------------------------
    // Two-flop synchroniser; mip sees an edge two clocks after it arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_s1 <= '0;
            r_irq_s2 <= '0;
        end else begin
            r_irq_s1 <= bus.irq;
            r_irq_s2 <= r_irq_s1;
        end
    end

    // ------------------------------------------------------------------
    // Trap-affected CSRs: trap entry beats MRET beats software write
    // ------------------------------------------------------------------
    // mstatus, mepc and mcause update on trap entry, MRET or CSR write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mepc         <= '0;
            r_mcause       <= '0;
        end else if (w_take_trap) begin
            r_mepc         <= bus.ex_pc[XLEN-1:2];
            r_mcause       <= w_exc ? c_cause_illegal : w_int_cause;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (w_do_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_csr_we) begin
            case (bus.csr_addr)
                c_addr_mstatus: begin
                    r_mstatus_mie  <= w_csr_new[3];
                    r_mstatus_mpie <= w_csr_new[7];
                end
                c_addr_mepc:   r_mepc   <= w_csr_new[XLEN-1:2];
                c_addr_mcause: r_mcause <= w_csr_new;
                default: ;
            endcase
        end
    end

    // Software-only CSRs: mie enables, mtvec and mscratch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mie_en     <= '0;
            r_mtvec_base <= MTVEC_RESET[XLEN-1:2];
            r_mscratch   <= '0;
`ifdef VECTORED_MTVEC_EN
            r_mtvec_mode <= c_mtvec_mode_rst;
`endif
        end else if (w_csr_we) begin
            case (bus.csr_addr)
                c_addr_mie:      r_mie_en <= w_csr_new[c_irq_base +: NUM_IRQ];
                c_addr_mscratch: r_mscratch <= w_csr_new;
                c_addr_mtvec: begin
                    r_mtvec_base <= w_csr_new[XLEN-1:2];
`ifdef VECTORED_MTVEC_EN
                    // Only direct (0) and vectored (1) are legal; 2/3 fall back to 0
                    r_mtvec_mode <= (w_csr_new[1:0] == 2'b01);
`endif
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Redirect FSM
    // ------------------------------------------------------------------
`ifdef VECTORED_MTVEC_EN
    // Interrupts in vectored mode jump to base + 4*cause; exceptions to base
    assign w_trap_target = {r_mtvec_base, 2'b00}
                         + ((r_mtvec_mode & r_mcause[XLEN-1])
                            ? XLEN'({r_mcause[4:0], 2'b00}) : '0);
`else
    assign w_trap_target = {r_mtvec_base, 2'b00};
`endif

    // State register; reset drops any in-flight redirect immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and redirect outputs; TRAP and RET each last one cycle
    always_comb begin
        w_state_nxt      = r_state;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = '0;
        w_busy           = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_take_trap) begin
                    w_state_nxt = ST_TRAP;
                end else if (w_do_mret) begin
                    w_state_nxt = ST_RET;
                end
            end
            ST_TRAP: begin
                w_redirect_valid = 1'b1;
                w_redirect_pc    = w_trap_target;
                w_busy           = 1'b1;
                w_state_nxt      = ST_RUN;
            end
            ST_RET: begin
                w_redirect_valid = 1'b1;
                w_redirect_pc    = {r_mepc, 2'b00};
                w_busy           = 1'b1;
                w_state_nxt      = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign bus.csr_rdata      = w_csr_old;
    assign bus.redirect_valid = w_redirect_valid;
    assign bus.redirect_pc    = w_redirect_pc;
    assign bus.busy           = w_busy;
    assign bus.ex_suppress    = w_take_trap;

endmodule

`default_nettype wire

// File: tb/tb_trap_csr_unit.sv
// ============================================================================
// Module      : tb_trap_csr_unit
// Description : Directed self-checking bench for trap_csr_unit: reset state,
//               CSR set/clear/write, illegal-instruction trap, interrupt trap
//               with MRET, masked interrupts, priority and reset-in-TRAP.
//               Honours VECTORED_MTVEC_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_csr_unit;

    localparam int XLEN    = 32;
    localparam int NUM_IRQ = 4;

    localparam logic [11:0] c_mstatus  = 12'h300;
    localparam logic [11:0] c_mie      = 12'h304;
    localparam logic [11:0] c_mtvec    = 12'h305;
    localparam logic [11:0] c_mscratch = 12'h340;
    localparam logic [11:0] c_mepc     = 12'h341;
    localparam logic [11:0] c_mcause   = 12'h342;
    localparam logic [11:0] c_mip      = 12'h344;

    localparam int c_op_write = 0;
    localparam int c_op_set   = 1;
    localparam int c_op_clear = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    trap_csr_unit_if #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) bus ();

    trap_csr_unit #(
        .XLEN        (XLEN),
        .NUM_IRQ     (NUM_IRQ),
        .MTVEC_RESET (32'h0000_0100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.instr_valid   = 1'b0;
        bus.csr_write     = 1'b0;
        bus.csr_set       = 1'b0;
        bus.csr_clear     = 1'b0;
        bus.illegal_instr = 1'b0;
        bus.mret          = 1'b0;
        bus.csr_wdata     = '0;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One CSR instruction: checks returned old value, then commits at the edge
    task automatic csr_op(input logic [11:0] a, input logic [31:0] d, input int kind,
                          input logic [31:0] exp_old, input string tag);
        idle();
        bus.instr_valid = 1'b1;
        bus.csr_addr    = a;
        bus.csr_wdata   = d;
        bus.csr_write   = (kind == c_op_write);
        bus.csr_set     = (kind == c_op_set);
        bus.csr_clear   = (kind == c_op_clear);
        #1;
        check(tag, bus.csr_rdata, exp_old);
        tick();
        idle();
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        idle();
        bus.csr_addr = a;
        #1;
        check(tag, bus.csr_rdata, exp);
    endtask

    // Plain valid instruction (no CSR op); checks whether a trap is accepted
    task automatic instr(input logic [31:0] pc, input logic exp_sup, input string tag);
        idle();
        bus.instr_valid = 1'b1;
        bus.ex_pc       = pc;
        #1;
        check(tag, 32'(bus.ex_suppress), 32'(exp_sup));
        tick();
        idle();
    endtask

    task automatic expect_redirect(input logic [31:0] pc, input string tag);
        #1;
        check({tag, "_valid"}, 32'(bus.redirect_valid), 32'd1);
        check({tag, "_busy"},  32'(bus.busy), 32'd1);
        check({tag, "_pc"},    bus.redirect_pc, pc);
        tick();
        #1;
        check({tag, "_done"},  32'(bus.redirect_valid), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle();
        bus.ex_pc    = '0;
        bus.csr_addr = c_mtvec;
        bus.irq      = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #3;
        check("rst_mtvec",    bus.csr_rdata, 32'h0000_0100);
        check("rst_redirect", 32'(bus.redirect_valid), 32'd0);
        check("rst_rpc",      bus.redirect_pc, 32'd0);
        check("rst_busy",     32'(bus.busy), 32'd0);
        check("rst_suppress", 32'(bus.ex_suppress), 32'd0);
        rst = 1'b0;
        tick();
        rd(c_mstatus, 32'h0000_1800, "rst_mstatus");
        rd(c_mcause,  32'h0,         "rst_mcause");

        // ---------------- mstatus set / clear ----------------
        csr_op(c_mstatus, 32'h8, c_op_set,   32'h0000_1800, "csrrs_old");
        rd(c_mstatus, 32'h0000_1808, "mie_set");
        csr_op(c_mstatus, 32'h8, c_op_clear, 32'h0000_1808, "csrrc_old");
        rd(c_mstatus, 32'h0000_1800, "mie_clr");

        // ---------------- illegal instruction trap ----------------
        csr_op(c_mtvec,   32'h200, c_op_write, 32'h0000_0100, "mtvec_old");
        csr_op(c_mstatus, 32'h8,   c_op_set,   32'h0000_1800, "mie_on1");
        idle();
        bus.instr_valid   = 1'b1;
        bus.illegal_instr = 1'b1;
        bus.ex_pc         = 32'h40;
        #1;
        check("ill_suppress", 32'(bus.ex_suppress), 32'd1);
        check("ill_noredir",  32'(bus.redirect_valid), 32'd0);
        tick();
        idle();
        expect_redirect(32'h200, "ill_redir");
        rd(c_mepc,    32'h40,        "ill_mepc");
        rd(c_mcause,  32'h2,         "ill_mcause");
        rd(c_mstatus, 32'h0000_1880, "ill_mstatus");

        // ---------------- interrupt trap and MRET ----------------
        csr_op(c_mie,     32'h0002_0000, c_op_write, 32'h0,         "mie_wr");
        csr_op(c_mstatus, 32'h8,         c_op_set,   32'h0000_1880, "mie_on2");
        bus.irq = 4'b0011;
        tick();
        rd(c_mip, 32'h0, "mip_lat1");
        tick();
        rd(c_mip, 32'h0003_0000, "mip_lat2");
        instr(32'h80, 1'b1, "irq_accept");
        expect_redirect(32'h200, "irq_redir");
        bus.irq = 4'b0000;
        rd(c_mcause,  32'h8000_0011, "irq_mcause");
        rd(c_mepc,    32'h80,        "irq_mepc");
        rd(c_mstatus, 32'h0000_1880, "irq_mstatus");
        idle();
        bus.instr_valid = 1'b1;
        bus.mret        = 1'b1;
        #1;
        check("mret_nosup", 32'(bus.ex_suppress), 32'd0);
        tick();
        idle();
        expect_redirect(32'h80, "mret_redir");
        rd(c_mstatus, 32'h0000_1888, "mret_mstatus");

        // ---------------- masked interrupt ----------------
        csr_op(c_mstatus, 32'h8, c_op_clear, 32'h0000_1888, "mie_off");
        bus.irq = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            instr(32'h1000 + 32'(i * 4), 1'b0, "masked");
        end
        csr_op(c_mstatus, 32'h8, c_op_set, 32'h0000_1880, "mie_on3");
        instr(32'h2000, 1'b1, "unmask_accept");
        expect_redirect(32'h200, "unmask_redir");
        rd(c_mcause, 32'h8000_0011, "unmask_mcause");

        // ---------------- exception beats interrupt ----------------
        csr_op(c_mstatus, 32'h8, c_op_set, 32'h0000_1880, "mie_on4");
        idle();
        bus.instr_valid   = 1'b1;
        bus.illegal_instr = 1'b1;
        bus.ex_pc         = 32'hC0;
        #1;
        check("prio_suppress", 32'(bus.ex_suppress), 32'd1);
        tick();
        idle();
        expect_redirect(32'h200, "prio_redir");
        rd(c_mcause, 32'h2, "prio_mcause");
        bus.irq = 4'b0000;

        // ---------------- plain CSRs ----------------
        csr_op(c_mscratch, 32'hDEAD_BEEF, c_op_write, 32'h0, "mscratch_old");
        rd(c_mscratch, 32'hDEAD_BEEF, "mscratch_rd");
        csr_op(c_mepc, 32'h1237, c_op_write, 32'hC0, "mepc_old");
        rd(c_mepc, 32'h1234, "mepc_align");
        csr_op(12'h123, 32'hFFFF_FFFF, c_op_write, 32'h0, "unimpl_old");
        rd(12'h123, 32'h0, "unimpl_rd");
        csr_op(c_mie, 32'hFFFF_FFFF, c_op_write, 32'h0002_0000, "mie_old");
        rd(c_mie, 32'h000F_0000, "mie_mask");

        // ---------------- mtvec mode, irq0, reset during TRAP ----------------
        csr_op(c_mtvec, 32'h301, c_op_write, 32'h200, "mtvec_wr");
`ifdef VECTORED_MTVEC_EN
        rd(c_mtvec, 32'h301, "mtvec_mode1");
        csr_op(c_mtvec, 32'h302, c_op_write, 32'h301, "mtvec_m2_old");
        rd(c_mtvec, 32'h300, "mtvec_m2_rd");
        csr_op(c_mtvec, 32'h301, c_op_write, 32'h300, "mtvec_m1_old");
`else
        rd(c_mtvec, 32'h300, "mtvec_nomode");
`endif
        csr_op(c_mie,     32'h0001_0000, c_op_write, 32'h000F_0000, "mie_irq0");
        csr_op(c_mstatus, 32'h8,         c_op_set,   32'h0000_1880, "mie_on5");
        bus.irq = 4'b0001;
        tick();
        tick();
        instr(32'h300, 1'b1, "irq0_accept");
        #1;
        check("irq0_valid", 32'(bus.redirect_valid), 32'd1);
`ifdef VECTORED_MTVEC_EN
        check("irq0_pc", bus.redirect_pc, 32'h340);
`else
        check("irq0_pc", bus.redirect_pc, 32'h300);
`endif
        rst = 1'b1;
        #1;
        check("rst_trap_valid", 32'(bus.redirect_valid), 32'd0);
        check("rst_trap_busy",  32'(bus.busy), 32'd0);
        rst = 1'b0;
        bus.irq = 4'b0000;
        tick();
        rd(c_mtvec,   32'h100,        "post_rst_mtvec");
        rd(c_mstatus, 32'h0000_1800,  "post_rst_mstatus");
        rd(c_mcause,  32'h0,          "post_rst_mcause");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
